eu_alu_way1: RTL and testbench

Way-1 integer execute stage, directly downstream of the way-1 EU operand register. Consumes one decoded RV64I instruction per valid/ready transfer, computes the ALU, branch or jump result, and presents a registered writeback packet to the way-1 writeback/commit stage. A two-entry output skid buffer keeps `ready_o` registered, so a downstream stall does not propagate combinationally upstream.

---
 rtl/eu_pkg.sv | 72 +++++++
 rtl/eu_skid_buffer.sv | 75 +++++++
 rtl/eu_alu_way1.sv | 153 +++++++++++++++
 tb/tb_eu_alu_way1.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eu_pkg.sv
// Shared definitions for the way-1 execute stage: RV64I opcodes, funct3
// encodings, the writeback packet and an opcode classifier.
package eu_pkg;

    localparam int EU_XLEN = 64;
    localparam int EU_ALEN = 32;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        CLS_ALU,
        CLS_ALUW,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_ILLEGAL
    } eu_cls_e;

    typedef struct packed {
        logic [4:0]         rdAddr;
        logic               rdWriteEnable;
        logic [EU_XLEN-1:0] rdWriteData;
        logic [1:0]         pID;
        logic               jumpFlag;
        logic [EU_ALEN-1:0] jumpAddr;
        logic               illegal;
    } eu_wb_pkt_t;

    localparam int EU_WB_PKT_W = $bits(eu_wb_pkt_t);

    function automatic eu_cls_e eu_classify(input logic [6:0] opc);
        eu_cls_e cls;
        case (opc)
            OPC_OP_IMM, OPC_OP:       cls = CLS_ALU;
            OPC_OP_IMM_32, OPC_OP_32: cls = CLS_ALUW;
            OPC_LUI:                  cls = CLS_LUI;
            OPC_AUIPC:                cls = CLS_AUIPC;
            OPC_JAL:                  cls = CLS_JAL;
            OPC_JALR:                 cls = CLS_JALR;
            OPC_BRANCH:               cls = CLS_BRANCH;
            default:                  cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/eu_skid_buffer.sv
// Two-entry valid/ready skid buffer: main entry drives the outputs, skid
// entry absorbs one packet so ready_o can be a plain register.
module eu_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    input  logic         ready_i
);

    logic [W-1:0] main_q, main_d, skid_q, skid_d;
    logic         main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic         ready_q;
    logic         accept, xfer;

    assign accept = valid_i & ready_q;
    assign xfer   = main_vld_q & ready_i;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (flush_i) begin
            main_d     = '0;
            main_vld_d = 1'b0;
            skid_d     = '0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || xfer) begin
            // Main is free this cycle: drain skid first to keep FIFO order.
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_d     = '0;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_d     = data_i;
                main_vld_d = 1'b1;
            end else begin
                main_d     = '0;
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = data_i;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            ready_q    <= ~skid_vld_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = main_vld_q;
    assign data_o  = main_q;

endmodule

// File: rtl/eu_alu_way1.sv
// Way-1 RV64I execute stage: combinational ALU/branch/jump compute on the
// incoming operands, registered through a two-entry skid buffer.
module eu_alu_way1
    import eu_pkg::*;
#(
    parameter int XLEN = EU_XLEN,
    parameter int ALEN = EU_ALEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [4:0]      rdAddr_i,
    input  logic            rdWriteEnable_i,
    input  logic [ALEN-1:0] instAddr_i,
    input  logic [XLEN-1:0] rs1ReadData_i,
    input  logic [XLEN-1:0] rs2ReadData_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [6:0]      opCode_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [5:0]      shamt_i,
    input  logic [1:0]      way1_pID_i,
    input  logic            ready_i,
    output logic            valid_o,
    output logic [4:0]      rdAddr_o,
    output logic            rdWriteEnable_o,
    output logic [XLEN-1:0] rdWriteData_o,
    output logic [1:0]      way1_pID_o,
    output logic            jumpFlag_o,
    output logic [ALEN-1:0] jumpAddr_o,
    output logic            illegal_o
);

    eu_cls_e    cls;
    logic       is_reg, alt;
    logic [XLEN-1:0] op_b, alu64;
    logic [5:0]      sh;
    logic [31:0]     a32, b32, alu32;
    logic [ALEN-1:0] pc4, pc_tgt;
    logic            taken, illegal;
    eu_wb_pkt_t      pkt_d, pkt_q;
    logic [EU_WB_PKT_W-1:0] pkt_bits;
    logic            unused_funct7;

    // Only funct7[5] distinguishes SUB/SRA; the rest is left to the decoder.
    assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

    assign cls    = eu_classify(opCode_i);
    assign is_reg = (opCode_i == OPC_OP) || (opCode_i == OPC_OP_32);
    assign alt    = funct7_i[5];
    assign op_b   = is_reg ? rs2ReadData_i : imm_i;
    assign sh     = is_reg ? rs2ReadData_i[5:0] : shamt_i;
    assign a32    = rs1ReadData_i[31:0];
    assign b32    = op_b[31:0];
    assign pc4    = instAddr_i + ALEN'(4);
    assign pc_tgt = instAddr_i + imm_i[ALEN-1:0];

    always_comb begin
        alu64 = '0;
        case (funct3_i)
            F3_ADD:  alu64 = (is_reg && alt) ? rs1ReadData_i - op_b : rs1ReadData_i + op_b;
            F3_SLL:  alu64 = rs1ReadData_i << sh;
            F3_SLT:  alu64 = {{(XLEN-1){1'b0}}, $signed(rs1ReadData_i) < $signed(op_b)};
            F3_SLTU: alu64 = {{(XLEN-1){1'b0}}, rs1ReadData_i < op_b};
            F3_XOR:  alu64 = rs1ReadData_i ^ op_b;
            F3_SR:   alu64 = alt ? XLEN'($signed(rs1ReadData_i) >>> sh) : rs1ReadData_i >> sh;
            F3_OR:   alu64 = rs1ReadData_i | op_b;
            F3_AND:  alu64 = rs1ReadData_i & op_b;
            default: alu64 = '0;
        endcase
    end

    // W ops only define ADD/SUB, SLL and SRL/SRA; other funct3 yield zero.
    always_comb begin
        alu32 = '0;
        case (funct3_i)
            F3_ADD:  alu32 = (is_reg && alt) ? a32 - b32 : a32 + b32;
            F3_SLL:  alu32 = a32 << sh[4:0];
            F3_SR:   alu32 = alt ? 32'($signed(a32) >>> sh[4:0]) : a32 >> sh[4:0];
            default: alu32 = '0;
        endcase
    end

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken = rs1ReadData_i == rs2ReadData_i;
            F3_BNE:  taken = rs1ReadData_i != rs2ReadData_i;
            F3_BLT:  taken = $signed(rs1ReadData_i) < $signed(rs2ReadData_i);
            F3_BGE:  taken = $signed(rs1ReadData_i) >= $signed(rs2ReadData_i);
            F3_BLTU: taken = rs1ReadData_i < rs2ReadData_i;
            F3_BGEU: taken = rs1ReadData_i >= rs2ReadData_i;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        pkt_d               = '0;
        pkt_d.rdAddr        = rdAddr_i;
        pkt_d.pID           = way1_pID_i;
        case (cls)
            CLS_ALU:   pkt_d.rdWriteData = alu64;
            CLS_ALUW:  pkt_d.rdWriteData = {{(XLEN-32){alu32[31]}}, alu32};
            CLS_LUI:   pkt_d.rdWriteData = imm_i;
            CLS_AUIPC: pkt_d.rdWriteData = {{(XLEN-ALEN){1'b0}}, instAddr_i} + imm_i;
            CLS_JAL: begin
                pkt_d.rdWriteData = {{(XLEN-ALEN){1'b0}}, pc4};
                pkt_d.jumpFlag    = 1'b1;
                pkt_d.jumpAddr    = pc_tgt;
            end
            CLS_JALR: begin
                pkt_d.rdWriteData = {{(XLEN-ALEN){1'b0}}, pc4};
                pkt_d.jumpFlag    = 1'b1;
                pkt_d.jumpAddr    = (rs1ReadData_i[ALEN-1:0] + imm_i[ALEN-1:0]) & ~ALEN'(1);
            end
            CLS_BRANCH: begin
                pkt_d.illegal  = illegal;
                pkt_d.jumpFlag = taken & ~illegal;
                pkt_d.jumpAddr = (taken & ~illegal) ? pc_tgt : '0;
            end
            default:   pkt_d.illegal = 1'b1;
        endcase
        pkt_d.rdWriteEnable = rdWriteEnable_i & ~pkt_d.illegal & (rdAddr_i != 5'd0) &
                              (cls != CLS_BRANCH);
    end

    eu_skid_buffer #(
        .W(EU_WB_PKT_W)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (pkt_d),
        .valid_o (valid_o),
        .data_o  (pkt_bits),
        .ready_i (ready_i)
    );

    assign pkt_q           = eu_wb_pkt_t'(pkt_bits);
    assign rdAddr_o        = pkt_q.rdAddr;
    assign rdWriteEnable_o = pkt_q.rdWriteEnable;
    assign rdWriteData_o   = pkt_q.rdWriteData;
    assign way1_pID_o      = pkt_q.pID;
    assign jumpFlag_o      = pkt_q.jumpFlag;
    assign jumpAddr_o      = pkt_q.jumpAddr;
    assign illegal_o       = pkt_q.illegal;

endmodule

// File: tb/tb_eu_alu_way1.sv
// Bench for eu_alu_way1: FIFO-of-expected-packets model checked every cycle,
// plus directed vectors with hand-computed literal results.
module tb_eu_alu_way1;
    import eu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [4:0]  rdAddr_i = '0;
    logic        rdWriteEnable_i = 1'b0;
    logic [31:0] instAddr_i = '0;
    logic [63:0] rs1ReadData_i = '0;
    logic [63:0] rs2ReadData_i = '0;
    logic [63:0] imm_i = '0;
    logic [6:0]  opCode_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [5:0]  shamt_i = '0;
    logic [1:0]  way1_pID_i = '0;
    logic        ready_i = 1'b1;
    logic        valid_o;
    logic [4:0]  rdAddr_o;
    logic        rdWriteEnable_o;
    logic [63:0] rdWriteData_o;
    logic [1:0]  way1_pID_o;
    logic        jumpFlag_o;
    logic [31:0] jumpAddr_o;
    logic        illegal_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [63:0] data;
        logic [1:0]  pid;
        logic        jf;
        logic [31:0] ja;
        logic        ill;
    } exp_t;

    exp_t q[$];

    eu_alu_way1 dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .rdAddr_i(rdAddr_i), .rdWriteEnable_i(rdWriteEnable_i), .instAddr_i(instAddr_i),
        .rs1ReadData_i(rs1ReadData_i), .rs2ReadData_i(rs2ReadData_i), .imm_i(imm_i),
        .opCode_i(opCode_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .shamt_i(shamt_i),
        .way1_pID_i(way1_pID_i), .ready_i(ready_i), .valid_o(valid_o), .rdAddr_o(rdAddr_o),
        .rdWriteEnable_o(rdWriteEnable_o), .rdWriteData_o(rdWriteData_o),
        .way1_pID_o(way1_pID_o), .jumpFlag_o(jumpFlag_o), .jumpAddr_o(jumpAddr_o),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of the instruction currently on the inputs.
    function automatic exp_t model();
        exp_t e;
        logic [63:0] a, b, r;
        logic [31:0] r32;
        logic [5:0]  s;
        bit isreg, sub, tk;
        e = '{rd: rdAddr_i, we: 1'b0, data: 64'd0, pid: way1_pID_i, jf: 1'b0, ja: 32'd0, ill: 1'b0};
        a = rs1ReadData_i;
        isreg = (opCode_i == 7'b0110011) || (opCode_i == 7'b0111011);
        b = isreg ? rs2ReadData_i : imm_i;
        s = isreg ? rs2ReadData_i[5:0] : shamt_i;
        sub = isreg && funct7_i[5];
        r = 64'd0;
        r32 = 32'd0;
        tk = 1'b0;
        case (opCode_i)
            7'b0010011, 7'b0110011: begin
                case (funct3_i)
                    3'd0: r = sub ? a - b : a + b;
                    3'd1: r = a << s;
                    3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                    3'd3: r = (a < b) ? 64'd1 : 64'd0;
                    3'd4: r = a ^ b;
                    3'd5: r = funct7_i[5] ? 64'($signed(a) >>> s) : a >> s;
                    3'd6: r = a | b;
                    default: r = a & b;
                endcase
                e.data = r;
            end
            7'b0011011, 7'b0111011: begin
                case (funct3_i)
                    3'd0: r32 = sub ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
                    3'd1: r32 = a[31:0] << s[4:0];
                    3'd5: r32 = funct7_i[5] ? 32'($signed(a[31:0]) >>> s[4:0]) : a[31:0] >> s[4:0];
                    default: r32 = 32'd0;
                endcase
                e.data = {{32{r32[31]}}, r32};
            end
            7'b0110111: e.data = imm_i;
            7'b0010111: e.data = {32'd0, instAddr_i} + imm_i;
            7'b1101111: begin
                e.data = {32'd0, instAddr_i + 32'd4};
                e.jf = 1'b1;
                e.ja = instAddr_i + imm_i[31:0];
            end
            7'b1100111: begin
                e.data = {32'd0, instAddr_i + 32'd4};
                e.jf = 1'b1;
                e.ja = (rs1ReadData_i[31:0] + imm_i[31:0]) & 32'hFFFF_FFFE;
            end
            7'b1100011: begin
                case (funct3_i)
                    3'd0: tk = rs1ReadData_i == rs2ReadData_i;
                    3'd1: tk = rs1ReadData_i != rs2ReadData_i;
                    3'd4: tk = $signed(rs1ReadData_i) < $signed(rs2ReadData_i);
                    3'd5: tk = $signed(rs1ReadData_i) >= $signed(rs2ReadData_i);
                    3'd6: tk = rs1ReadData_i < rs2ReadData_i;
                    3'd7: tk = rs1ReadData_i >= rs2ReadData_i;
                    default: e.ill = 1'b1;
                endcase
                e.jf = tk;
                e.ja = tk ? instAddr_i + imm_i[31:0] : 32'd0;
            end
            default: e.ill = 1'b1;
        endcase
        if (opCode_i != 7'b1100011)
            e.we = rdWriteEnable_i && !e.ill && (rdAddr_i != 5'd0);
        return e;
    endfunction

    // Per-cycle compare against the model FIFO, then advance it.
    always @(negedge clk) begin
        chk("valid_o", {63'd0, valid_o}, {63'd0, q.size() != 0});
        chk("ready_o", {63'd0, ready_o}, {63'd0, q.size() < 2});
        if (valid_o && q.size() != 0) begin
            chk("pkt.rdAddr", {59'd0, rdAddr_o}, {59'd0, q[0].rd});
            chk("pkt.rdWriteEnable", {63'd0, rdWriteEnable_o}, {63'd0, q[0].we});
            chk("pkt.rdWriteData", rdWriteData_o, q[0].data);
            chk("pkt.pID", {62'd0, way1_pID_o}, {62'd0, q[0].pid});
            chk("pkt.jumpFlag", {63'd0, jumpFlag_o}, {63'd0, q[0].jf});
            chk("pkt.jumpAddr", {32'd0, jumpAddr_o}, {32'd0, q[0].ja});
            chk("pkt.illegal", {63'd0, illegal_o}, {63'd0, q[0].ill});
        end
        if (reset || flush_i) begin
            q.delete();
        end else begin
            if (valid_o && ready_i && q.size() != 0) void'(q.pop_front());
            if (valid_i && ready_o) q.push_back(model());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [5:0] sh, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] im, input logic [31:0] pc, input logic [4:0] rd,
                         input logic we, input logic [1:0] pid);
        opCode_i = opc; funct3_i = f3; funct7_i = f7; shamt_i = sh;
        rs1ReadData_i = a; rs2ReadData_i = b; imm_i = im; instAddr_i = pc;
        rdAddr_i = rd; rdWriteEnable_i = we; way1_pID_i = pid;
        valid_i = 1'b1;
    endtask

    // Hold the packet until accepted; a stuck ready_o counts as a failure.
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [5:0] sh, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] im, input logic [31:0] pc, input logic [4:0] rd,
                        input logic we, input logic [1:0] pid);
        bit acc;
        drive(opc, f3, f7, sh, a, b, im, pc, rd, we, pid);
        for (int n = 0; n < 20; n++) begin
            acc = ready_o;
            tick();
            if (acc) break;
            if (n == 19) begin
                checks++;
                errors++;
                $display("FAIL send-timeout: ready_o stayed %b, required 1", ready_o);
            end
        end
        valid_i = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".valid_o"}, {63'd0, valid_o}, 64'd0);
        chk({tag, ".ready_o"}, {63'd0, ready_o}, 64'd1);
        chk({tag, ".rdWriteData_o"}, rdWriteData_o, 64'd0);
        chk({tag, ".rdAddr_o"}, {59'd0, rdAddr_o}, 64'd0);
        chk({tag, ".rdWriteEnable_o"}, {63'd0, rdWriteEnable_o}, 64'd0);
        chk({tag, ".jumpFlag_o"}, {63'd0, jumpFlag_o}, 64'd0);
        chk({tag, ".jumpAddr_o"}, {32'd0, jumpAddr_o}, 64'd0);
        chk({tag, ".illegal_o"}, {63'd0, illegal_o}, 64'd0);
        chk({tag, ".pID_o"}, {62'd0, way1_pID_o}, 64'd0);
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        chk_reset_state("reset");
        ready_i = 1'b1;

        send(7'b0110011, 3'd0, 7'd0, 6'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 32'h0, 5'd5, 1'b1, 2'd0);
        chk("add.data", rdWriteData_o, 64'h8000_0000_0000_0000);
        chk("add.valid", {63'd0, valid_o}, 64'd1);
        chk("add.rd", {59'd0, rdAddr_o}, 64'd5);
        chk("add.we", {63'd0, rdWriteEnable_o}, 64'd1);

        send(7'b0111011, 3'd0, 7'd0, 6'd0, 64'h7FFF_FFFF, 64'd1, 64'd0, 32'h0, 5'd6, 1'b1, 2'd1);
        chk("addw.data", rdWriteData_o, 64'hFFFF_FFFF_8000_0000);

        send(7'b0010011, 3'd5, 7'b0100000, 6'd63, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 32'h0, 5'd7, 1'b1, 2'd2);
        chk("srai.data", rdWriteData_o, 64'hFFFF_FFFF_FFFF_FFFF);

        send(7'b1100011, 3'd4, 7'd0, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0,
             32'h8000_0010, 5'd3, 1'b1, 2'd3);
        chk("blt.jumpFlag", {63'd0, jumpFlag_o}, 64'd1);
        chk("blt.jumpAddr", {32'd0, jumpAddr_o}, 64'h8000_0000);
        chk("blt.we", {63'd0, rdWriteEnable_o}, 64'd0);

        send(7'b1100111, 3'd0, 7'd0, 6'd0, 64'h1003, 64'd0, 64'd0, 32'h100, 5'd1, 1'b1, 2'd0);
        chk("jalr.jumpAddr", {32'd0, jumpAddr_o}, 64'h1002);
        chk("jalr.data", rdWriteData_o, 64'h104);

        // Model-checked mix: SUB, SLTU, SRLW, AUIPC, LUI, BNE not taken, bad branch, x0, JAL.
        send(7'b0110011, 3'd0, 7'b0100000, 6'd0, 64'd5, 64'd7, 64'd0, 32'h0, 5'd8, 1'b1, 2'd1);
        chk("sub.data", rdWriteData_o, 64'hFFFF_FFFF_FFFF_FFFE);
        send(7'b0110011, 3'd3, 7'd0, 6'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 32'h0, 5'd9, 1'b1, 2'd2);
        send(7'b0111011, 3'd5, 7'd0, 6'd0, 64'h1_8000_0000, 64'd4, 64'd0, 32'h0, 5'd10, 1'b1, 2'd3);
        chk("srlw.data", rdWriteData_o, 64'h0800_0000);
        send(7'b0010111, 3'd0, 7'd0, 6'd0, 64'd0, 64'd0, 64'h1000, 32'hFFFF_F000, 5'd11, 1'b1, 2'd0);
        chk("auipc.data", rdWriteData_o, 64'h1_0000_0000);
        send(7'b0110111, 3'd0, 7'd0, 6'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_ABCD_E000, 32'h0, 5'd12, 1'b1, 2'd1);
        send(7'b1100011, 3'd1, 7'd0, 6'd0, 64'd9, 64'd9, 64'd64, 32'h200, 5'd0, 1'b0, 2'd2);
        chk("bne.jumpFlag", {63'd0, jumpFlag_o}, 64'd0);
        send(7'b1100011, 3'd2, 7'd0, 6'd0, 64'd1, 64'd2, 64'd8, 32'h300, 5'd0, 1'b0, 2'd3);
        chk("br010.illegal", {63'd0, illegal_o}, 64'd1);
        send(7'b0010011, 3'd0, 7'd0, 6'd0, 64'd1, 64'd0, 64'd1, 32'h0, 5'd0, 1'b1, 2'd0);
        chk("x0.we", {63'd0, rdWriteEnable_o}, 64'd0);
        send(7'b1101111, 3'd0, 7'd0, 6'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 5'd1, 1'b1, 2'd1);
        chk("jal.data", rdWriteData_o, 64'h0);
        chk("jal.jumpAddr", {32'd0, jumpAddr_o}, 64'hFFFF_FFF8);

        send(7'b0000011, 3'd3, 7'd0, 6'd0, 64'd4, 64'd0, 64'd0, 32'h0, 5'd7, 1'b1, 2'd2);
        chk("load.illegal", {63'd0, illegal_o}, 64'd1);
        chk("load.we", {63'd0, rdWriteEnable_o}, 64'd0);
        chk("load.data", rdWriteData_o, 64'd0);
        tick();

        // Back-pressure: two accepted, third held off until the stall clears.
        ready_i = 1'b0;
        send(7'b0010011, 3'd0, 7'd0, 6'd0, 64'd100, 64'd0, 64'd1, 32'h0, 5'd1, 1'b1, 2'd0);
        send(7'b0010011, 3'd0, 7'd0, 6'd0, 64'd200, 64'd0, 64'd2, 32'h0, 5'd2, 1'b1, 2'd1);
        chk("bp.ready_full", {63'd0, ready_o}, 64'd0);
        drive(7'b0010011, 3'd0, 7'd0, 6'd0, 64'd300, 64'd0, 64'd3, 32'h0, 5'd3, 1'b1, 2'd2);
        repeat (3) tick();
        chk("bp.hold_pid", {62'd0, way1_pID_o}, 64'd0);
        chk("bp.hold_data", rdWriteData_o, 64'd101);
        chk("bp.hold_ready", {63'd0, ready_o}, 64'd0);
        ready_i = 1'b1;
        tick();
        chk("bp.second_pid", {62'd0, way1_pID_o}, 64'd1);
        chk("bp.ready_back", {63'd0, ready_o}, 64'd1);
        tick();
        valid_i = 1'b0;
        chk("bp.third_pid", {62'd0, way1_pID_o}, 64'd2);
        chk("bp.third_data", rdWriteData_o, 64'd303);
        tick();
        tick();

        // Flush with both entries full and a packet on the input.
        ready_i = 1'b0;
        send(7'b0110111, 3'd0, 7'd0, 6'd0, 64'd0, 64'd0, 64'h11, 32'h0, 5'd4, 1'b1, 2'd0);
        send(7'b0110111, 3'd0, 7'd0, 6'd0, 64'd0, 64'd0, 64'h22, 32'h0, 5'd4, 1'b1, 2'd1);
        drive(7'b0110111, 3'd0, 7'd0, 6'd0, 64'd0, 64'd0, 64'h33, 32'h0, 5'd4, 1'b1, 2'd2);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("flush.valid_o", {63'd0, valid_o}, 64'd0);
        chk("flush.ready_o", {63'd0, ready_o}, 64'd1);
        ready_i = 1'b1;
        repeat (4) tick();
        chk("flush.quiet", {63'd0, valid_o}, 64'd0);

        // Reset mid-stall with a jump held at the output.
        ready_i = 1'b0;
        send(7'b1101111, 3'd0, 7'd0, 6'd0, 64'd0, 64'd0, 64'h40, 32'h1000, 5'd1, 1'b1, 2'd3);
        chk("rst.pre_jump", {63'd0, jumpFlag_o}, 64'd1);
        send(7'b0000011, 3'd0, 7'd0, 6'd0, 64'd0, 64'd0, 64'd0, 32'h0, 5'd2, 1'b1, 2'd1);
        reset = 1'b1;
        tick();
        chk_reset_state("midreset");
        reset = 1'b0;
        ready_i = 1'b1;
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
